// File: rtl/arf132b256e1r1w0cbbehcaa4acw_pkg.sv
// Shared constants and FSM state type for the arf132b256e1r1w0cbbehcaa4acw write controller.
//   DATA_W : write-data width of the register-file array
//   DEPTH  : number of array entries
//   ADR_W  : array address width, $clog2(DEPTH)
//   wr_state_e : controller FSM states (StInit walks the array to zero, StReady serves writes)
package arf132b256e1r1w0cbbehcaa4acw_pkg;

  localparam int unsigned DATA_W = 132;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADR_W  = $clog2(DEPTH);

  typedef enum logic [0:0] {
    StInit  = 1'b0,
    StReady = 1'b1
  } wr_state_e;

endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_ctech_doublesync_rstb.sv
// Two-flop synchroniser cell with asynchronous active-low reset.
//   d    : asynchronous level input
//   clk  : destination clock
//   rstb : asynchronous active-low reset, clears both stages
//   q    : synchronised level, two clk edges after d settles
module arf132b256e1r1w0cbbehcaa4acw_ctech_doublesync_rstb (
  input  logic d,
  input  logic clk,
  input  logic rstb,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_wr_ctl.sv
// Write-port controller for a DEPTH x DATA_W register-file array.
// Accepts valid/ready writes and presents them registered (latency 1) on the array write port.
// Optional array initialisation, enabled by defining ARF132B256E1R1W0CBBEHCAA4ACW_WR_CTL_INIT_EN:
// after reset, or on a rising edge of the synchronised init_req, every entry is written with zero
// before writes are accepted again. Without the macro the block comes up ready and ignores init_req.
//   clk, rstb              : clock, asynchronous active-low reset
//   wr_vld/wr_rdy          : upstream write handshake
//   wr_adr, wr_data        : upstream write address / data
//   init_req               : asynchronous level request to re-initialise the array
//   arr_wr_en/adr/data     : registered array write port
//   arr_clk_en             : array write clock-gate enable (same as arr_wr_en)
//   init_done              : array initialised and block ready
module arf132b256e1r1w0cbbehcaa4acw_wr_ctl #(
  parameter  int unsigned DATA_W = arf132b256e1r1w0cbbehcaa4acw_pkg::DATA_W,
  parameter  int unsigned DEPTH  = arf132b256e1r1w0cbbehcaa4acw_pkg::DEPTH,
  localparam int unsigned ADR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init_req,
  output logic              arr_wr_en,
  output logic [ADR_W-1:0]  arr_wr_adr,
  output logic [DATA_W-1:0] arr_wr_data,
  output logic              arr_clk_en,
  output logic              init_done
);

  import arf132b256e1r1w0cbbehcaa4acw_pkg::*;

  // DEPTH widened by one bit so the range check also covers DEPTH == 2**ADR_W.
  localparam logic [ADR_W:0] DepthExt = (ADR_W + 1)'(DEPTH);

  wr_state_e         r_state;
  wr_state_e         w_state_d;
  logic              r_init_done;
  logic              w_init_done_d;
  logic              r_arr_wr_en;
  logic              w_arr_wr_en_d;
  logic [ADR_W-1:0]  r_arr_wr_adr;
  logic [ADR_W-1:0]  w_arr_wr_adr_d;
  logic [DATA_W-1:0] r_arr_wr_data;
  logic [DATA_W-1:0] w_arr_wr_data_d;
  logic              w_accept;
  logic              w_adr_ok;
  logic              w_init_pend;

`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_WR_CTL_INIT_EN
  localparam wr_state_e        ResetState = StInit;
  localparam logic [ADR_W-1:0] AdrLast    = ADR_W'(DEPTH - 1);

  logic             w_sync;
  logic             r_sync_prev;
  logic             w_sync_rise;
  logic             r_init_pend;
  logic             w_init_pend_d;
  logic [ADR_W-1:0] r_cnt;
  logic [ADR_W-1:0] w_cnt_d;
  logic             w_init_last;

  arf132b256e1r1w0cbbehcaa4acw_ctech_doublesync_rstb u_init_sync (
    .d    (init_req),
    .clk  (clk),
    .rstb (rstb),
    .q    (w_sync)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt       <= '0;
      r_init_pend <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_d;
      r_init_pend <= w_init_pend_d;
      r_sync_prev <= w_sync;
    end
  end

  assign w_sync_rise = w_sync && !r_sync_prev;
  assign w_init_pend = r_init_pend;
  // The last zero write is on the array port; INIT always starts with arr_wr_en low, so this
  // cannot be confused with a user write that landed just before INIT was entered.
  assign w_init_last = r_arr_wr_en && (r_arr_wr_adr == AdrLast);
`else
  localparam wr_state_e ResetState = StReady;

  logic w_unused_init_req;
  assign w_unused_init_req = init_req;
  assign w_init_pend       = 1'b0;
`endif

  assign wr_rdy   = r_init_done && !w_init_pend;
  assign w_accept = wr_vld && wr_rdy;
  assign w_adr_ok = ({1'b0, wr_adr} < DepthExt);

  always_comb begin
    w_state_d       = r_state;
    w_arr_wr_en_d   = 1'b0;
    w_arr_wr_adr_d  = r_arr_wr_adr;
    w_arr_wr_data_d = r_arr_wr_data;
`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_WR_CTL_INIT_EN
    w_cnt_d         = r_cnt;
    w_init_pend_d   = r_init_pend;
`endif

    unique case (r_state)
      StReady: begin
        // Out-of-range addresses are accepted but never reach the array.
        if (w_accept && w_adr_ok) begin
          w_arr_wr_en_d   = 1'b1;
          w_arr_wr_adr_d  = wr_adr;
          w_arr_wr_data_d = wr_data;
        end
`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_WR_CTL_INIT_EN
        if (r_init_pend) begin
          w_state_d     = StInit;
          w_cnt_d       = '0;
          w_init_pend_d = 1'b0;
        end else if (w_sync_rise) begin
          w_init_pend_d = 1'b1;
        end
`endif
      end
      StInit: begin
`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_WR_CTL_INIT_EN
        if (w_init_last) begin
          w_state_d = StReady;
        end else begin
          w_arr_wr_en_d   = 1'b1;
          w_arr_wr_adr_d  = r_cnt;
          w_arr_wr_data_d = '0;
          w_cnt_d         = (r_cnt == AdrLast) ? '0 : r_cnt + 1'b1;
        end
`else
        w_state_d = StReady;
`endif
      end
      default: w_state_d = ResetState;
    endcase

    w_init_done_d = (w_state_d == StReady);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state       <= ResetState;
      r_init_done   <= 1'b0;
      r_arr_wr_en   <= 1'b0;
      r_arr_wr_adr  <= '0;
      r_arr_wr_data <= '0;
    end else begin
      r_state       <= w_state_d;
      r_init_done   <= w_init_done_d;
      r_arr_wr_en   <= w_arr_wr_en_d;
      r_arr_wr_adr  <= w_arr_wr_adr_d;
      r_arr_wr_data <= w_arr_wr_data_d;
    end
  end

  assign arr_wr_en   = r_arr_wr_en;
  assign arr_clk_en  = r_arr_wr_en;
  assign arr_wr_adr  = r_arr_wr_adr;
  assign arr_wr_data = r_arr_wr_data;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_wr_ctl.sv
// Self-checking bench for arf132b256e1r1w0cbbehcaa4acw_wr_ctl (either build of the init feature).
module tb_arf132b256e1r1w0cbbehcaa4acw_wr_ctl;

  localparam int unsigned DATA_W = 132;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADR_W  = 8;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              wr_vld = 1'b0;
  logic [ADR_W-1:0]  wr_adr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              init_req = 1'b0;
  logic              wr_rdy;
  logic              arr_wr_en;
  logic [ADR_W-1:0]  arr_wr_adr;
  logic [DATA_W-1:0] arr_wr_data;
  logic              arr_clk_en;
  logic              init_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  arf132b256e1r1w0cbbehcaa4acw_wr_ctl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .wr_vld      (wr_vld),
    .wr_rdy      (wr_rdy),
    .wr_adr      (wr_adr),
    .wr_data     (wr_data),
    .init_req    (init_req),
    .arr_wr_en   (arr_wr_en),
    .arr_wr_adr  (arr_wr_adr),
    .arr_wr_data (arr_wr_data),
    .arr_clk_en  (arr_clk_en),
    .init_done   (init_done)
  );

  // Reference model: what the array port shows after each edge.
  bit                m_en;
  logic [ADR_W-1:0]  m_adr;
  logic [DATA_W-1:0] m_data;
  bit                m_done;   // block ready / array initialised
  bit                m_pend;   // re-init requested, not yet started
  int                m_idx;    // next zero-write address during init, -1 when not initialising
  bit                m_s1, m_s2, m_s2p;

`ifdef ARF132B256E1R1W0CBBEHCAA4ACW_WR_CTL_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  task automatic model_reset();
    m_en   = 1'b0;
    m_adr  = '0;
    m_data = '0;
    m_done = 1'b0;
    m_pend = 1'b0;
    m_idx  = InitEn ? 0 : -1;
    m_s1   = 1'b0;
    m_s2   = 1'b0;
    m_s2p  = 1'b0;
  endtask

  task automatic model_edge();
    bit rdy;
    bit rise;
    rdy  = m_done && !m_pend;
    rise = 1'b0;
    if (InitEn) begin
      rise  = m_s2 && !m_s2p;
      m_s2p = m_s2;
      m_s2  = m_s1;
      m_s1  = init_req;
    end
    m_en = 1'b0;
    if (m_idx >= 0) begin
      if (m_idx == int'(DEPTH)) begin
        m_idx  = -1;
        m_done = 1'b1;
      end else begin
        m_en   = 1'b1;
        m_adr  = 8'(m_idx);
        m_data = '0;
        m_idx++;
      end
    end else if (m_pend) begin
      m_pend = 1'b0;
      m_idx  = 0;
      m_done = 1'b0;
    end else begin
      if (wr_vld && rdy) begin
        m_en   = 1'b1;
        m_adr  = wr_adr;
        m_data = wr_data;
      end
      if (rise && m_done) m_pend = 1'b1;
      m_done = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"},    DATA_W'(arr_wr_en),  DATA_W'(m_en));
    chk({tag, ".clken"}, DATA_W'(arr_clk_en), DATA_W'(m_en));
    chk({tag, ".adr"},   DATA_W'(arr_wr_adr), DATA_W'(m_adr));
    chk({tag, ".data"},  arr_wr_data,         m_data);
    chk({tag, ".done"},  DATA_W'(init_done),  DATA_W'(m_done));
    chk({tag, ".rdy"},   DATA_W'(wr_rdy),     DATA_W'(m_done && !m_pend));
  endtask

  // One clock: model follows the edge, outputs checked 1 ns later; inputs then free to change.
  task automatic cyc(input string tag);
    @(posedge clk);
    if (!rstb) model_reset();
    else model_edge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic wait_ready(input string tag, input int bound);
    int n;
    n = 0;
    while (!(m_done && !m_pend) && n < bound) begin
      cyc(tag);
      n++;
    end
    chk({tag, ".bounded"}, DATA_W'(m_done && !m_pend), DATA_W'(1'b1));
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    int n;
    model_reset();

    // Held in reset: everything low.
    cyc("rst0");
    cyc("rst1");

    // Release between edges; first edges show either the zero walk or immediate readiness.
    rstb = 1'b1;
    cyc("boot");
    chk("boot.done_first", DATA_W'(init_done), DATA_W'(!InitEn));
    wait_ready("boot_init", 400);
    cyc("boot_idle");

    // Single write, then idle.
    pat     = {4'hA, {16{8'h5A}}};
    wr_vld  = 1'b1;
    wr_adr  = 8'h5A;
    wr_data = pat;
    cyc("wr5a");
    chk("wr5a.direct_adr", DATA_W'(arr_wr_adr), DATA_W'(8'h5A));
    wr_vld = 1'b0;
    cyc("wr5a_idle");
    chk("wr5a.direct_en_off", DATA_W'(arr_wr_en), DATA_W'(1'b0));

    // Back-to-back writes with no bubbles.
    for (int i = 1; i <= 3; i++) begin
      wr_vld  = 1'b1;
      wr_adr  = 8'(i);
      wr_data = rnd_data();
      cyc("b2b");
    end
    wr_vld = 1'b0;
    cyc("b2b_idle");

    // Streaming writes with an init request arriving mid-stream.
    for (int i = 0; i < 10; i++) begin
      wr_vld  = 1'b1;
      wr_adr  = 8'($urandom_range(0, 255));
      wr_data = rnd_data();
      if (i == 2) init_req = 1'b1;
      cyc("stream_req");
    end
    wait_ready("reinit", 600);
    init_req = 1'b0;
    wr_vld   = 1'b0;
    for (int i = 0; i < 4; i++) cyc("reinit_idle");

    // Randomised traffic with occasional init_req toggles.
    for (int i = 0; i < 400; i++) begin
      wr_vld  = ($urandom_range(0, 3) != 0);
      wr_adr  = 8'($urandom());
      wr_data = rnd_data();
      if ($urandom_range(0, 79) == 0) init_req = ~init_req;
      cyc("rand");
    end
    init_req = 1'b0;
    wr_vld   = 1'b0;
    wait_ready("rand_settle", 600);
    for (int i = 0; i < 4; i++) cyc("rand_idle");

    // Asynchronous reset in the middle of activity.
    if (InitEn) begin
      init_req = 1'b1;
      n = 0;
      while (!(m_en && m_adr == 8'h80 && m_idx >= 0) && n < 700) begin
        cyc("to_80");
        n++;
      end
      chk("to_80.bounded", DATA_W'(arr_wr_adr), DATA_W'(8'h80));
    end else begin
      wr_vld  = 1'b1;
      wr_adr  = 8'hC3;
      wr_data = rnd_data();
      cyc("pre_rst_wr");
      wr_vld = 1'b0;
    end
    #2;
    rstb = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    cyc("in_rst");
    init_req = 1'b0;
    rstb     = 1'b1;
    cyc("restart");
    if (InitEn) chk("restart.adr0", DATA_W'(arr_wr_adr), DATA_W'(8'h00));
    wait_ready("restart_init", 400);
    wr_vld  = 1'b1;
    wr_adr  = 8'hFF;
    wr_data = rnd_data();
    cyc("final_wr");
    wr_vld = 1'b0;
    cyc("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
